imem_tcm_ctrl: RTL
==================

IMEM_TCM_CTRL -- requirements
Module: imem_tcm_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit instruction words stored; a power of two.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, range 0..7: extra response delay, in cycles.
REQ-004 SHALL use one clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-005 SHALL have port clk, input, 1: core clock.
REQ-006 SHALL have port rst, input, 1: synchronous reset, active high.
REQ-007 SHALL have port imem_req_i, input, 1: core IMEM request valid.
REQ-008 SHALL have port imem_cmd_i, input, 1: 0 = READ, 1 = WRITE.
REQ-009 SHALL have port imem_addr_i, input, 32: byte address.
REQ-010 SHALL have port imem_req_ack_o, output, 1: request accepted this cycle.
REQ-011 SHALL have port imem_rdata_o, output, 32: instruction word.
REQ-012 SHALL have port imem_resp_o, output, 2: 00 IDLE, 01 RDY, 10 ER.
REQ-013 SHALL have port init_we_i, input, 1: loader write strobe.
REQ-014 SHALL have port init_addr_i, input, log2(DEPTH_WORDS): loader word index.
REQ-015 SHALL have port init_wdata_i, input, 32: loader data.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 SHALL drive imem_req_ack_o = (state==IDLE or state==RESP) and not init_we_i.
REQ-018 SHALL treat a request as accepted when imem_req_i and imem_req_ack_o are both high; it SHALL sample cmd and addr in that cycle and start the synchronous RAM read.
REQ-019 SHALL classify an accepted request as an error if any of these hold: cmd=WRITE; addr[1:0]!=0; addr < BASE_ADDR; addr >= BASE_ADDR+4*DEPTH_WORDS.
REQ-020 Transitions, WAIT_CYCLES=0: an accept goes to RESP.
REQ-021 Transitions, WAIT_CYCLES>0: an accept goes to WAIT; WAIT counts WAIT_CYCLES cycles and then goes to RESP.
REQ-022 Transitions: RESP with a new accept follows REQ-020/REQ-021; RESP without an accept goes to IDLE.
REQ-023 SHALL drive imem_resp_o RDY or ER for exactly one cycle in RESP, 1+WAIT_CYCLES cycles after the accept; otherwise it SHALL drive IDLE.
REQ-024 SHALL drive imem_rdata_o with RAM[(addr-BASE_ADDR)>>2] on RDY, 0 on ER, and hold the last value during IDLE.
REQ-025 SHALL capture the read word into a holding register so that loader writes after the accept do not alter the response.
REQ-026 SHALL, with WAIT_CYCLES=0, sustain one accept and one response per cycle on back-to-back requests.
REQ-027 SHALL write init_wdata_i to RAM[init_addr_i] on the clock edge where init_we_i is high, in any state.
REQ-028 SHALL never have a loader write and a core accept in the same cycle.
REQ-029 SHALL compute the word index with wrap-free subtraction; any address outside the window SHALL never index the RAM.

Reset
REQ-030 SHALL, while rst is high, force state=IDLE, clear the wait counter, drive imem_resp_o=IDLE and imem_rdata_o=0.
REQ-031 SHALL drop a request outstanding at reset with no response; imem_req_ack_o SHALL follow REQ-017 in the first cycle after reset.
REQ-032 SHALL NOT clear RAM contents on reset.

Structure
REQ-033 SHALL place the resp enum (IDLE/RDY/ER), cmd enum (READ/WRITE) and FSM state enum in shared package imem_tcm_pkg.
REQ-034 SHALL instantiate one sub-module, imem_tcm_sram: synchronous single-clock RAM with one read port and one write port, 1-cycle read latency, DEPTH_WORDS x 32.

Verification
REQ-035 SHALL cover: load RAM[3]=32'h0000_0013; WAIT_CYCLES=0; READ addr 0x0C -> ack same cycle, resp=RDY and rdata=32'h13 on the next cycle only.
REQ-036 SHALL cover: WAIT_CYCLES=2; READ addr 0x0C -> resp=RDY exactly 3 cycles after accept; ack low during WAIT.
REQ-037 SHALL cover: READ 0x0E, WRITE 0x0C and READ 0x1000 (DEPTH_WORDS=1024) -> resp=ER, rdata=0 each time.
REQ-038 SHALL cover: 8 back-to-back READs 0x00..0x1C at WAIT_CYCLES=0 -> 8 consecutive RDY cycles with the matching words.
REQ-039 SHALL cover: init_we_i held high with imem_req_i high -> ack=0 and no accept; accept on the first cycle after init_we_i drops.
REQ-040 SHALL cover: rst asserted in WAIT -> no response; resp=IDLE; RAM contents unchanged on the next read.

Source files
------------

// File: rtl/imem_tcm_pkg.sv
// Shared types for the instruction TCM controller.
//   imem_resp_e  : response code driven on imem_resp_o (IDLE / RDY / ER)
//   imem_cmd_e   : request command on imem_cmd_i (READ / WRITE)
//   imem_state_e : controller FSM state
package imem_tcm_pkg;

  typedef enum logic [1:0] {
    RespIdle = 2'b00,
    RespRdy  = 2'b01,
    RespErr  = 2'b10
  } imem_resp_e;

  typedef enum logic {
    CmdRead  = 1'b0,
    CmdWrite = 1'b1
  } imem_cmd_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } imem_state_e;

  // Wide enough for WAIT_CYCLES up to 7.
  localparam int unsigned WaitCntW = 3;

endpackage

// File: rtl/imem_tcm_sram.sv
// Single-clock instruction RAM, DEPTH_WORDS x 32, one read port and one write port.
//   clk_i             : clock
//   re_i / raddr_i    : read enable and word index; rdata_o valid the cycle after re_i
//   rdata_o           : registered read data, held until the next read
//   we_i / waddr_i    : write enable and word index
//   wdata_i           : write data
// Contents are not reset.
module imem_tcm_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_tcm_ctrl.sv
// Instruction tightly-coupled memory controller.
// Accepts core read requests into a DEPTH_WORDS x 32 RAM mapped at BASE_ADDR, answers each
// with a one-cycle RDY/ER pulse 1+WAIT_CYCLES cycles after the accept, and lets a loader
// write the RAM at any time (the core is never accepted in a loader cycle).
//   clk, rst          : clock, synchronous active-high reset
//   imem_req_i        : core request valid
//   imem_cmd_i        : 0 READ, 1 WRITE (WRITE is answered with ER)
//   imem_addr_i       : byte address
//   imem_req_ack_o    : request accepted this cycle when imem_req_i is also high
//   imem_rdata_o      : instruction word on RDY, 0 on ER, last value otherwise
//   imem_resp_o       : 00 IDLE, 01 RDY, 10 ER
//   init_we_i         : loader write strobe
//   init_addr_i       : loader word index
//   init_wdata_i      : loader data
module imem_tcm_ctrl
  import imem_tcm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          imem_req_i,
  input  logic          imem_cmd_i,
  input  logic [31:0]   imem_addr_i,
  output logic          imem_req_ack_o,
  output logic [31:0]   imem_rdata_o,
  output logic [1:0]    imem_resp_o,
  input  logic          init_we_i,
  input  logic [AW-1:0] init_addr_i,
  input  logic [31:0]   init_wdata_i
);

  localparam logic [32:0] WindowBytes = 33'(64'(DEPTH_WORDS) * 64'd4);
  localparam logic [WaitCntW-1:0] WaitLast =
      (WAIT_CYCLES > 0) ? WaitCntW'(WAIT_CYCLES - 1) : '0;

  imem_state_e         state_q, state_d;
  logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
  logic                err_q;
  logic                fresh_q;    // RAM read port holds the word of the last accept
  logic [31:0]         word_q;     // captured read word, immune to later loader writes
  logic [31:0]         last_q;     // last value presented on imem_rdata_o in RESP

  logic                accept;
  logic                above_base, in_window, aligned, req_err;
  logic [31:0]         offset;
  logic [AW-1:0]       ram_raddr;
  logic [31:0]         ram_rdata;
  logic [31:0]         resp_data;

  // Decode. offset is only meaningful when above_base, so the subtraction never wraps
  // into the window; out-of-window addresses present index 0 and do not enable the read.
  always_comb begin
    offset     = imem_addr_i - BASE_ADDR;
    above_base = (imem_addr_i >= BASE_ADDR);
    in_window  = above_base && ({1'b0, offset} < WindowBytes);
    aligned    = (imem_addr_i[1:0] == 2'b00);
    req_err    = (imem_cmd_e'(imem_cmd_i) == CmdWrite) || !aligned || !in_window;
    ram_raddr  = in_window ? offset[AW+1:2] : '0;
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    imem_req_ack_o = ((state_q == StIdle) || (state_q == StResp)) && !init_we_i;
    accept         = imem_req_i && imem_req_ack_o;

    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d    = StWait;
            wait_cnt_d = '0;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (wait_cnt_q == WaitLast) begin
          state_d = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // With no wait states the RESP cycle directly follows the accept, so the word is taken
  // straight from the RAM port; otherwise from the capture register.
  always_comb begin
    resp_data = err_q ? 32'h0 : (fresh_q ? ram_rdata : word_q);
    if (rst) begin
      imem_resp_o  = RespIdle;
      imem_rdata_o = 32'h0;
    end else if (state_q == StResp) begin
      imem_resp_o  = err_q ? RespErr : RespRdy;
      imem_rdata_o = resp_data;
    end else begin
      imem_resp_o  = RespIdle;
      imem_rdata_o = last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      fresh_q    <= 1'b0;
      word_q     <= 32'h0;
      last_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fresh_q    <= accept;
      if (accept) begin
        err_q <= req_err;
      end
      if (fresh_q) begin
        word_q <= ram_rdata;
      end
      if (state_q == StResp) begin
        last_q <= resp_data;
      end
    end
  end

  imem_tcm_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk_i  (clk),
    .re_i   (accept && !req_err),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata),
    .we_i   (init_we_i),
    .waddr_i(init_addr_i),
    .wdata_i(init_wdata_i)
  );

endmodule
